// File: rtl/parport_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : parport_input_conditioner_if
// Purpose  : Pin/conduit bundle between the parallel-port input conditioner
//            and its consumer.
// Revision : 1.0  initial release
// ============================================================================
interface parport_input_conditioner_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] pins_i;
   logic [WIDTH-1:0] stable_o;
   logic [WIDTH-1:0] rise_o;
   logic [WIDTH-1:0] fall_o;
   logic [WIDTH-1:0] flags_o;
   logic [WIDTH-1:0] clear_i;
   logic [WIDTH-1:0] irq_mask_i;
   logic             irq_o;

   // The conditioner is the slave; whoever owns the pins and reads the
   // conduit is the master.
   modport slave (
      input  pins_i,
      input  clear_i,
      input  irq_mask_i,
      output stable_o,
      output rise_o,
      output fall_o,
      output flags_o,
      output irq_o
   );

   modport master (
      output pins_i,
      output clear_i,
      output irq_mask_i,
      input  stable_o,
      input  rise_o,
      input  fall_o,
      input  flags_o,
      input  irq_o
   );
endinterface
`default_nettype wire

// File: rtl/parport_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : parport_input_conditioner
// Purpose  : Synchronizes and debounces WIDTH raw pins, emits rise/fall
//            pulses, sticky change flags and a masked interrupt.
// Revision : 1.0  initial release
// ============================================================================
module parport_input_conditioner #(
   parameter int               WIDTH           = 8,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
   input  wire logic                   clk,
   input  wire logic                   reset_n,
   parport_input_conditioner_if.slave  bus
);

   localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] rise_q,   rise_d;
   logic [WIDTH-1:0] fall_q,   fall_d;
   logic [WIDTH-1:0] flags_q,  flags_d;
   logic             irq_q,    irq_d;
   logic [WIDTH-1:0] update_w;

   // Two-flop synchronizer; only sync2_q is ever consumed downstream.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= RESET_VALUE;
         sync2_q <= RESET_VALUE;
      end else begin
         sync1_q <= bus.pins_i;
         sync2_q <= sync1_q;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             accept_w;

      // Any agreement with the accepted level restarts the full count.
      always_comb begin
         cnt_d    = cnt_q;
         accept_w = 1'b0;
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_MAX) begin
            cnt_d    = '0;
            accept_w = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign update_w[i] = accept_w;
   end

   always_comb begin
      stable_d = stable_q ^ update_w;
      rise_d   = update_w & sync2_q;
      fall_d   = update_w & ~sync2_q;
      // A new change on the same edge as a clear keeps the flag set.
      flags_d  = (flags_q & ~bus.clear_i) | update_w;
      irq_d    = |(flags_q & bus.irq_mask_i);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_q <= RESET_VALUE;
         rise_q   <= '0;
         fall_q   <= '0;
         flags_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         flags_q  <= flags_d;
         irq_q    <= irq_d;
      end
   end

   assign bus.stable_o = stable_q;
   assign bus.rise_o   = rise_q;
   assign bus.fall_o   = fall_q;
   assign bus.flags_o  = flags_q;
   assign bus.irq_o    = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_parport_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_parport_input_conditioner
// Purpose  : Directed bench with a history-based reference model for the
//            parallel-port input conditioner (DEBOUNCE_CYCLES=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_parport_input_conditioner;

   localparam int        W  = 8;
   localparam int        D  = 4;
   localparam logic [7:0] RV = 8'h00;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   logic started = 1'b0;

   int n_total = 0;
   int n_pass  = 0;

   parport_input_conditioner_if #(.WIDTH(W)) bus ();

   parport_input_conditioner #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .RESET_VALUE     (RV)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Reference: a level is accepted once the synchronized pin has disagreed
   // with the accepted level on each of the last D edges.
   logic [7:0] m_s1, m_s2, m_stable, m_rise, m_fall, m_flags;
   logic       m_irq;
   logic [7:0] hist[$];

   function automatic logic [7:0] accepted_now();
      logic [7:0] acc;
      acc = 8'h00;
      if (hist.size() == D) begin
         for (int b = 0; b < W; b++) begin
            acc[b] = 1'b1;
            foreach (hist[k]) if (hist[k][b] == m_stable[b]) acc[b] = 1'b0;
         end
      end
      return acc;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist.delete();
         m_s1 <= RV; m_s2 <= RV; m_stable <= RV;
         m_rise <= 8'h00; m_fall <= 8'h00; m_flags <= 8'h00; m_irq <= 1'b0;
      end else begin
         hist.push_back(m_s2);
         if (hist.size() > D) void'(hist.pop_front());
         m_irq    <= |(m_flags & bus.irq_mask_i);
         m_rise   <= accepted_now() & m_s2;
         m_fall   <= accepted_now() & ~m_s2;
         m_flags  <= (m_flags & ~bus.clear_i) | accepted_now();
         m_stable <= m_stable ^ accepted_now();
         m_s2     <= m_s1;
         m_s1     <= bus.pins_i;
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("model_stable", bus.stable_o, m_stable);
         chk("model_rise",   bus.rise_o,   m_rise);
         chk("model_fall",   bus.fall_o,   m_fall);
         chk("model_flags",  bus.flags_o,  m_flags);
         chk("model_irq",    {7'd0, bus.irq_o}, {7'd0, m_irq});
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bus.pins_i     = 8'hFF;
      bus.clear_i    = 8'h00;
      bus.irq_mask_i = 8'h00;
      #1 reset_n = 1'b0;
      started = 1'b1;

      // Reset with pins high, then release
      cyc(3);
      chk("rst_stable", bus.stable_o, 8'h00);
      chk("rst_rise",   bus.rise_o,   8'h00);
      chk("rst_flags",  bus.flags_o,  8'h00);
      chk("rst_irq",    {7'd0, bus.irq_o}, 8'h00);
      reset_n = 1'b1;
      cyc(5); chk("t1_edge5_stable", bus.stable_o, 8'h00);
      cyc(1); chk("t1_edge6_stable", bus.stable_o, 8'hFF);
              chk("t1_edge6_rise",   bus.rise_o,   8'hFF);
              chk("t1_edge6_flags",  bus.flags_o,  8'hFF);
      cyc(1); chk("t1_rise_drop",    bus.rise_o,   8'h00);
              chk("t1_flags_sticky", bus.flags_o,  8'hFF);
      bus.pins_i = 8'h00;
      cyc(8);
      bus.clear_i = 8'hFF; cyc(1); bus.clear_i = 8'h00;
      cyc(1); chk("t1_flags_cleared", bus.flags_o, 8'h00);

      // Glitch: 3-cycle pulse discarded, 4-cycle hold accepted
      bus.pins_i = 8'h01; cyc(3); bus.pins_i = 8'h00;
      cyc(10); chk("t2_glitch_stable", bus.stable_o, 8'h00);
               chk("t2_glitch_flags",  bus.flags_o,  8'h00);
      bus.pins_i = 8'h01;
      cyc(5); chk("t2_edge5_stable", bus.stable_o, 8'h00);
      cyc(1); chk("t2_edge6_stable", bus.stable_o, 8'h01);
              chk("t2_edge6_rise",   bus.rise_o,   8'h01);

      // Bounce on bit 3: 1,0,1 then held
      bus.pins_i = 8'h09; cyc(1);
      bus.pins_i = 8'h01; cyc(1);
      bus.pins_i = 8'h09;
      cyc(5); chk("t3_edge5_stable", bus.stable_o, 8'h01);
      cyc(1); chk("t3_edge6_stable", bus.stable_o, 8'h09);
              chk("t3_fall",         bus.fall_o,   8'h00);
      cyc(2);

      // Flag set/clear race on bit 2
      bus.clear_i = 8'hFF; cyc(1); bus.clear_i = 8'h00;
      bus.irq_mask_i = 8'h04;
      cyc(2); chk("t4_irq_idle", {7'd0, bus.irq_o}, 8'h00);
      bus.pins_i = 8'h0D;
      cyc(5); bus.clear_i = 8'h04;
      cyc(1); chk("t4_race_flags", bus.flags_o, 8'h04);
              chk("t4_race_rise",  bus.rise_o,  8'h04);
      cyc(1); chk("t4_clear_flags", bus.flags_o, 8'h00);
              chk("t4_irq_high",    {7'd0, bus.irq_o}, 8'h01);
      bus.clear_i = 8'h00;
      cyc(1); chk("t4_irq_drop", {7'd0, bus.irq_o}, 8'h00);

      // IRQ mask on an already-set flag
      bus.irq_mask_i = 8'h00;
      bus.pins_i = 8'h1D;
      cyc(8); chk("t5_flags", bus.flags_o, 8'h10);
              chk("t5_irq_masked", {7'd0, bus.irq_o}, 8'h00);
      bus.irq_mask_i = 8'h10;
      cyc(1); chk("t5_irq_unmasked", {7'd0, bus.irq_o}, 8'h01);

      // Reset while bit 5 is mid-count
      bus.pins_i = 8'h3D;
      cyc(4);
      #2 reset_n = 1'b0;
      #1 chk("t6_async_stable", bus.stable_o, 8'h00);
         chk("t6_async_flags",  bus.flags_o,  8'h00);
      cyc(2);
      reset_n = 1'b1;
      cyc(5); chk("t6_edge5_stable", bus.stable_o, 8'h00);
      cyc(1); chk("t6_edge6_stable", bus.stable_o, 8'h3D);
              chk("t6_edge6_rise",   bus.rise_o,   8'h3D);
      cyc(3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
